// File: rtl/sound_gen.sv
`default_nettype none
// ============================================================================
// Module      : sound_gen
// Description : Two-tone square-wave sound generator with edge-triggered
//               requests, tone-2 priority and a mute gate on the speaker.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_gen #(
  parameter int HALF_PERIOD_1 = 28409,
  parameter int HALF_PERIOD_2 = 14205,
  parameter int DURATION_1    = 2500000,
  parameter int DURATION_2    = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_sound1,
  input  logic       play_sound2,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] tone_id
);

  localparam logic [15:0] C_HP1_LAST  = 16'(HALF_PERIOD_1 - 1);
  localparam logic [15:0] C_HP2_LAST  = 16'(HALF_PERIOD_2 - 1);
  localparam logic [23:0] C_DUR1_LAST = 24'(DURATION_1 - 1);
  localparam logic [23:0] C_DUR2_LAST = 24'(DURATION_2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TONE1 = 2'd1,
    ST_TONE2 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_prev1;
  logic        r_prev2;
  logic        w_rise1;
  logic        w_rise2;
  logic [15:0] r_hp_cnt;
  logic [15:0] w_hp_cnt_next;
  logic [23:0] r_dur_cnt;
  logic [23:0] w_dur_cnt_next;
  logic        r_wave;
  logic        w_wave_next;
  logic        w_tone_active;
  logic [15:0] w_hp_last;
  logic [23:0] w_dur_last;
  logic [1:0]  w_tone_id_next;
  logic        r_speaker;
  logic        r_busy;
  logic [1:0]  r_tone_id;

  // Previous-level registers reset high so a request held through reset
  // release is not mistaken for a new rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev1 <= 1'b1;
      r_prev2 <= 1'b1;
    end else begin
      r_prev1 <= play_sound1;
      r_prev2 <= play_sound2;
    end
  end

  assign w_rise1 = play_sound1 & ~r_prev1;
  assign w_rise2 = play_sound2 & ~r_prev2;

  assign w_tone_active = (r_state == ST_TONE1) || (r_state == ST_TONE2);
  assign w_hp_last     = (r_state == ST_TONE2) ? C_HP2_LAST  : C_HP1_LAST;
  assign w_dur_last    = (r_state == ST_TONE2) ? C_DUR2_LAST : C_DUR1_LAST;

  always_comb begin
    w_state_next   = r_state;
    w_hp_cnt_next  = r_hp_cnt;
    w_dur_cnt_next = r_dur_cnt;
    w_wave_next    = r_wave;

    if (w_rise2) begin
      w_state_next   = ST_TONE2;
      w_hp_cnt_next  = 16'd0;
      w_dur_cnt_next = 24'd0;
      w_wave_next    = 1'b1;
    end else if (w_rise1 && (r_state != ST_TONE2)) begin
      w_state_next   = ST_TONE1;
      w_hp_cnt_next  = 16'd0;
      w_dur_cnt_next = 24'd0;
      w_wave_next    = 1'b1;
    end else if (w_tone_active) begin
      if (r_dur_cnt == w_dur_last) begin
        w_state_next   = ST_IDLE;
        w_hp_cnt_next  = 16'd0;
        w_dur_cnt_next = 24'd0;
        w_wave_next    = 1'b0;
      end else begin
        w_dur_cnt_next = r_dur_cnt + 24'd1;
        if (r_hp_cnt == w_hp_last) begin
          w_hp_cnt_next = 16'd0;
          w_wave_next   = ~r_wave;
        end else begin
          w_hp_cnt_next = r_hp_cnt + 16'd1;
        end
      end
    end else begin
      // Idle (or an unreachable encoding): park everything at zero.
      w_state_next   = ST_IDLE;
      w_hp_cnt_next  = 16'd0;
      w_dur_cnt_next = 24'd0;
      w_wave_next    = 1'b0;
    end
  end

  always_comb begin
    w_tone_id_next = 2'd0;
    case (w_state_next)
      ST_TONE1: w_tone_id_next = 2'd1;
      ST_TONE2: w_tone_id_next = 2'd2;
      default:  w_tone_id_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_hp_cnt  <= 16'd0;
      r_dur_cnt <= 24'd0;
      r_wave    <= 1'b0;
      r_speaker <= 1'b0;
      r_busy    <= 1'b0;
      r_tone_id <= 2'd0;
    end else begin
      r_state   <= w_state_next;
      r_hp_cnt  <= w_hp_cnt_next;
      r_dur_cnt <= w_dur_cnt_next;
      r_wave    <= w_wave_next;
      r_speaker <= w_wave_next & ~mute;
      r_busy    <= (w_state_next != ST_IDLE);
      r_tone_id <= w_tone_id_next;
    end
  end

  assign speaker = r_speaker;
  assign busy    = r_busy;
  assign tone_id = r_tone_id;

endmodule
`default_nettype wire
